decod: RTL and testbench



---
 rtl/decod.sv | 126 ++++++++++++
 tb/tb_decod.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decod.sv
// Registered state-index to one-hot LED decoder with out-of-range flag and change strobe.
// Optional blink window on state changes is built when DECOD_BLINK_EN is defined.
module decod #(
    parameter int unsigned N_LEDS       = 4,
    parameter int unsigned STATE_W      = 2,
    parameter int unsigned ACTIVE_LOW   = 0,
    parameter int unsigned BLINK_DIV    = 8,
    parameter int unsigned BLINK_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] state,
    output logic [N_LEDS-1:0]  led_indicator,
    output logic               state_changed,
    output logic               invalid
);

    localparam int unsigned CMP_W = STATE_W + 1;
    localparam logic [CMP_W-1:0] N_LEDS_C = CMP_W'(N_LEDS);
    localparam logic [N_LEDS-1:0] LED_OFF = {N_LEDS{ACTIVE_LOW != 0}};

    // Elaboration-time parameter sanity checks
    if (N_LEDS < 2 || N_LEDS > 64) begin : g_bad_n_leds
        $error("decod: N_LEDS must be in 2..64");
    end
    if ((64'd1 << STATE_W) < 64'(N_LEDS)) begin : g_bad_state_w
        $error("decod: STATE_W too narrow for N_LEDS");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("decod: BLINK_DIV must be >= 1");
    end
    if (BLINK_CYCLES > 32'h7fff_ffff) begin : g_bad_blink_cycles
        $error("decod: BLINK_CYCLES out of range");
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic [N_LEDS-1:0]  led_q, led_d;
    logic               changed_q, changed_d;
    logic               invalid_q, invalid_d;
    logic [N_LEDS-1:0]  onehot;
    logic [N_LEDS-1:0]  lit;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(N_LEDS); i++) begin
            onehot[i] = (state == STATE_W'(i));
        end
    end

    always_comb begin
        state_d   = state;
        changed_d = (state != state_q);
        invalid_d = ({1'b0, state} >= N_LEDS_C);
    end

`ifdef DECOD_BLINK_EN
    localparam int unsigned DIV_W = $clog2(BLINK_DIV + 1);
    localparam int unsigned WIN_W = (BLINK_CYCLES < 1) ? 1 : $clog2(BLINK_CYCLES + 1);

    logic [WIN_W-1:0] win_q, win_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;

    // win_q counts remaining window cycles after the one being displayed; phase starts lit
    always_comb begin
        win_d   = win_q;
        div_d   = div_q;
        phase_d = phase_q;
        if (changed_d && (BLINK_CYCLES > 0)) begin
            win_d   = WIN_W'(BLINK_CYCLES - 1);
            div_d   = DIV_W'(BLINK_DIV - 1);
            phase_d = 1'b1;
        end else if (win_q != '0) begin
            win_d = win_q - WIN_W'(1);
            if (div_q == '0) begin
                div_d   = DIV_W'(BLINK_DIV - 1);
                phase_d = ~phase_q;
            end else begin
                div_d = div_q - DIV_W'(1);
            end
        end else begin
            phase_d = 1'b1;
        end
        lit = onehot & {N_LEDS{phase_d}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            win_q   <= win_d;
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end
`else
    always_comb begin
        lit = onehot;
    end
`endif

    always_comb begin
        led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            led_q     <= LED_OFF;
            changed_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            changed_q <= changed_d;
            invalid_q <= invalid_d;
        end
    end

    assign led_indicator = led_q;
    assign state_changed = changed_q;
    assign invalid       = invalid_q;

endmodule

// File: tb/tb_decod.sv
// Directed self-checking bench for decod: default, N_LEDS=3, active-low and blink instances.
module tb_decod;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    logic [1:0] state_b;

    logic [3:0] led_m, led_al, led_b;
    logic [2:0] led_3;
    logic       chg_m, chg_3, chg_al, chg_b;
    logic       inv_m, inv_3, inv_al, inv_b;

    int checks   = 0;
    int failures = 0;

    decod #(.N_LEDS(4), .STATE_W(2), .ACTIVE_LOW(0), .BLINK_DIV(2), .BLINK_CYCLES(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .state(state),
        .led_indicator(led_m), .state_changed(chg_m), .invalid(inv_m));

    decod #(.N_LEDS(3), .STATE_W(2), .ACTIVE_LOW(0), .BLINK_DIV(2), .BLINK_CYCLES(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .state(state),
        .led_indicator(led_3), .state_changed(chg_3), .invalid(inv_3));

    decod #(.N_LEDS(4), .STATE_W(2), .ACTIVE_LOW(1), .BLINK_DIV(2), .BLINK_CYCLES(0)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .state(state),
        .led_indicator(led_al), .state_changed(chg_al), .invalid(inv_al));

    decod #(.N_LEDS(4), .STATE_W(2), .ACTIVE_LOW(0), .BLINK_DIV(2), .BLINK_CYCLES(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .state(state_b),
        .led_indicator(led_b), .state_changed(chg_b), .invalid(inv_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] s);
        state = s;
        tick();
    endtask

    int         pulses;
    logic [7:0] pat;

    initial begin
`ifdef DECOD_BLINK_EN
        pat = 8'b0011_0011;
`else
        pat = 8'hFF;
`endif
        rst_n   = 1'b0;
        state   = 2'd3;
        state_b = 2'd0;
        #12;
        chk("rst_led",    64'(led_m),  64'h0);
        chk("rst_inv",    64'(inv_m),  64'h0);
        chk("rst_chg",    64'(chg_m),  64'h0);
        chk("rst_led3",   64'(led_3),  64'h0);
        chk("rst_inv3",   64'(inv_3),  64'h0);
        chk("rst_led_al", 64'(led_al), 64'hF);
        chk("rst_inv_al", 64'(inv_al), 64'h0);

        rst_n = 1'b1;
        tick();
        chk("s3_led",    64'(led_m),  64'h8);
        chk("s3_chg",    64'(chg_m),  64'h1);
        chk("s3_inv",    64'(inv_m),  64'h0);
        chk("s3_led3",   64'(led_3),  64'h0);
        chk("s3_inv3",   64'(inv_3),  64'h1);
        chk("s3_led_al", 64'(led_al), 64'h7);
        chk("s3_inv_al", 64'(inv_al), 64'h0);
        tick();
        chk("s3_hold_chg", 64'(chg_m), 64'h0);
        chk("s3_hold_led", 64'(led_m), 64'h8);
        for (int i = 0; i < 8; i++) tick();

        step(2'd2);
        chk("s2_led",    64'(led_m),  64'h4);
        chk("s2_chg",    64'(chg_m),  64'h1);
        chk("s2_led3",   64'(led_3),  64'h4);
        chk("s2_inv3",   64'(inv_3),  64'h0);
        chk("s2_led_al", 64'(led_al), 64'hB);
        for (int i = 0; i < 9; i++) tick();

        step(2'd1);
        chk("s1_led",    64'(led_m),  64'h2);
        chk("s1_chg",    64'(chg_m),  64'h1);
        chk("s1_led3",   64'(led_3),  64'h2);
        chk("s1_led_al", 64'(led_al), 64'hD);
        chk("s1_chg_al", 64'(chg_al), 64'h1);
        for (int i = 0; i < 9; i++) tick();

        step(2'd0);
        chk("s0_led", 64'(led_m), 64'h1);
        chk("s0_chg", 64'(chg_m), 64'h1);
        chk("s0_inv", 64'(inv_m), 64'h0);
        for (int i = 0; i < 9; i++) tick();

        // hold state 2 for 20 cycles: exactly one pulse
        state  = 2'd2;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (chg_m) pulses++;
        end
        chk("hold2_pulses", 64'(pulses), 64'd1);
        chk("hold2_led",    64'(led_m),  64'h4);

        // invalid on N_LEDS=3, then recovery
        step(2'd3);
        chk("inv3_led", 64'(led_3), 64'h0);
        chk("inv3_inv", 64'(inv_3), 64'h1);
        chk("inv3_chg", 64'(chg_3), 64'h1);
        step(2'd1);
        chk("rec3_led", 64'(led_3), 64'h2);
        chk("rec3_inv", 64'(inv_3), 64'h0);
        // back-to-back change gives consecutive pulses
        step(2'd3);
        chk("b2b_chg0", 64'(chg_m), 64'h1);
        chk("b2b_led0", 64'(led_m), 64'h8);
        step(2'd0);
        chk("b2b_chg1", 64'(chg_m), 64'h1);
        chk("b2b_led1", 64'(led_m), 64'h1);
        step(2'd2);

        // asynchronous mid-cycle reset
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led",    64'(led_m),  64'h0);
        chk("arst_chg",    64'(chg_m),  64'h0);
        chk("arst_led_al", 64'(led_al), 64'hF);
        state = 2'd0;
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_led", 64'(led_m), 64'h1);
        chk("post_rst_chg", 64'(chg_m), 64'h0);
        chk("post_rst_inv", 64'(inv_m), 64'h0);

        // blink window 0 -> 2
        tick();
        state_b = 2'd2;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("blink2_%0d", k), 64'(led_b[2]), 64'(pat[k]));
            chk($sformatf("blink2_oth_%0d", k), 64'(led_b & 4'b1011), 64'h0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("steady2_%0d", k), 64'(led_b), 64'h4);
        end

        // restart mid-window on a new LED
        state_b = 2'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("blink1_%0d", k), 64'(led_b[1]), 64'(pat[k]));
        end
        state_b = 2'd3;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("blink3_%0d", k), 64'(led_b[3]), 64'(pat[k]));
            chk($sformatf("blink3_oth_%0d", k), 64'(led_b & 4'b0111), 64'h0);
        end
        tick();
        chk("steady3", 64'(led_b), 64'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
